// File: rtl/pwm_multi_gen_if.sv
// Purpose : bundles the PWM generator's run controls, duty-load strobe and outputs.
// Latency : n/a (signal grouping only).
// Backpressure: none. duty_vld is a one-cycle strobe that is always accepted.
// Ports (master = controller side, slave = generator side):
//   en, center_mode, duty[NUM_CH*WIDTH], duty_vld     master -> slave
//   PWM_sig[NUM_CH], PWM_synch, OVR_I_blank_n, upd_pend  slave -> master
interface pwm_multi_gen_if #(
    parameter int WIDTH  = 11,
    parameter int NUM_CH = 3
);
    logic                      en;
    logic                      center_mode;
    logic [NUM_CH*WIDTH-1:0]   duty;
    logic                      duty_vld;
    logic [NUM_CH-1:0]         PWM_sig;
    logic                      PWM_synch;
    logic                      OVR_I_blank_n;
    logic                      upd_pend;

    modport master (
        output en, center_mode, duty, duty_vld,
        input  PWM_sig, PWM_synch, OVR_I_blank_n, upd_pend
    );

    modport slave (
        input  en, center_mode, duty, duty_vld,
        output PWM_sig, PWM_synch, OVR_I_blank_n, upd_pend
    );
endinterface

// File: rtl/pwm_multi_gen.sv
// Purpose : multi-channel PWM with a shared edge/center-aligned counter, double-buffered duties,
//           a period sync pulse and an over-current blanking window after every output edge.
// Latency : PWM_sig lags the counter by 1 cycle. New duty/mode takes effect at the next period boundary.
// Backpressure: none. duty_vld is always accepted, and the last write before a boundary wins.
// Ports: clk, rst_n (async active-low), bus (pwm_multi_gen_if.slave):
//   en, center_mode, duty, duty_vld in; PWM_sig, PWM_synch, OVR_I_blank_n, upd_pend out.
module pwm_multi_gen #(
    parameter int WIDTH     = 11,
    parameter int NUM_CH    = 3,
    parameter int BLANK_CYC = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    pwm_multi_gen_if.slave    bus
);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam int               BW       = $clog2(BLANK_CYC + 1);
    localparam logic [BW-1:0]    BLANK_LD = BW'(BLANK_CYC);

    logic [WIDTH-1:0]  cnt;
    logic              dir_dn;      // 1 = counting down (center mode, second half)
    logic              mode_act;    // 1 = center-aligned for the current period
    logic [WIDTH-1:0]  shadow [NUM_CH];
    logic [WIDTH-1:0]  active [NUM_CH];
    logic [NUM_CH-1:0] pwm_q;
    logic [NUM_CH-1:0] pwm_nxt;
    logic              upd_q;
    logic [BW-1:0]     blk_cnt;
    logic              boundary;

    // The boundary is the cycle whose clock edge reloads cnt to 0. It doubles as the sync pulse.
    always_comb begin
        boundary = bus.en && (mode_act ? (dir_dn && (cnt == CNT_ONE)) : (cnt == CNT_MAX));
    end

    always_comb begin
        pwm_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_nxt[i] = bus.en && (cnt < active[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            dir_dn   <= 1'b0;
            mode_act <= 1'b0;
            upd_q    <= 1'b0;
            pwm_q    <= '0;
            blk_cnt  <= BLANK_LD;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (bus.duty_vld) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    shadow[i] <= bus.duty[i*WIDTH +: WIDTH];
                end
            end

            if (!bus.en || boundary) begin
                // The active set always takes the shadow value from before this edge. A duty_vld
                // arriving on the same edge stays pending until the following boundary.
                cnt      <= '0;
                dir_dn   <= 1'b0;
                mode_act <= bus.center_mode;
                upd_q    <= bus.duty_vld;
                for (int i = 0; i < NUM_CH; i++) begin
                    active[i] <= shadow[i];
                end
            end else begin
                if (bus.duty_vld) begin
                    upd_q <= 1'b1;
                end
                if (mode_act && dir_dn) begin
                    cnt <= cnt - 1'b1;
                end else if (mode_act && (cnt == CNT_MAX)) begin
                    cnt    <= cnt - 1'b1;
                    dir_dn <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            pwm_q <= pwm_nxt;

            // Any edge on any channel restarts the blanking window. Otherwise the counter drains to 0.
            if (pwm_nxt != pwm_q) begin
                blk_cnt <= BLANK_LD;
            end else if (blk_cnt != '0) begin
                blk_cnt <= blk_cnt - 1'b1;
            end
        end
    end

    assign bus.PWM_sig       = pwm_q;
    assign bus.PWM_synch     = boundary;
    assign bus.OVR_I_blank_n = (blk_cnt == '0);
    assign bus.upd_pend      = upd_q;
endmodule

// File: tb/tb_pwm_multi_gen.sv
// Purpose : directed bench for pwm_multi_gen (WIDTH=8, NUM_CH=3, BLANK_CYC=16).
// Latency : each step measures whole periods, delimited by PWM_synch.
// Backpressure: n/a.
module tb_pwm_multi_gen;
    localparam int WIDTH     = 8;
    localparam int NUM_CH    = 3;
    localparam int BLANK_CYC = 16;
    localparam int DW        = NUM_CH * WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pwm_multi_gen_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) bus ();

    pwm_multi_gen #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .BLANK_CYC(BLANK_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    // Per-period measurements. The window runs from the cycle after one sync pulse up to and
    // including the next sync pulse.
    int m_len;
    int m_hi [NUM_CH];
    int m_rise0;
    int m_first0;
    int m_maxlow;
    int m_upd;
    int m_end_upd;

    task automatic check(input string tag, input int obs);
        int expv;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL %s: scoreboard empty, observed %0d", tag, obs);
        end else begin
            expv = exp_q.pop_front();
            assert (obs === expv) else begin
                fails++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
            end
        end
    endtask

    task automatic wait_synch(input string tag, input int budget);
        int n;
        n = 0;
        exp_q.push_back(1);
        do begin
            @(negedge clk);
            n++;
        end while (bus.PWM_synch !== 1'b1 && n < budget);
        check(tag, int'(bus.PWM_synch));
    endtask

    // Must be entered on the negedge that shows PWM_synch=1. Sample index k corresponds to cnt=k
    // while counting up. A duty/mode write is injected at sample index inj.
    task automatic measure(input int inj, input logic [DW-1:0] inj_duty, input logic inj_cm);
        logic [NUM_CH-1:0] prev;
        int run;
        prev     = bus.PWM_sig;
        m_len    = 0;
        m_hi     = '{default: 0};
        m_rise0  = 0;
        m_first0 = 0;
        m_maxlow = 0;
        m_upd    = 0;
        run      = 0;
        do begin
            @(negedge clk);
            bus.duty_vld = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.PWM_sig[c]) m_hi[c]++;
            end
            if (bus.PWM_sig[0] && !prev[0]) m_rise0++;
            if (m_len == 0) m_first0 = int'(bus.PWM_sig[0]);
            if (!bus.OVR_I_blank_n) begin
                run++;
                if (run > m_maxlow) m_maxlow = run;
            end else begin
                run = 0;
            end
            if (bus.upd_pend) m_upd++;
            prev = bus.PWM_sig;
            if (m_len == inj) begin
                bus.duty        = inj_duty;
                bus.duty_vld    = 1'b1;
                bus.center_mode = inj_cm;
            end
            m_len++;
        end while (bus.PWM_synch !== 1'b1 && m_len < 2000);
        m_end_upd = int'(bus.upd_pend);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en          = 1'b0;
        bus.center_mode = 1'b0;
        bus.duty        = '0;
        bus.duty_vld    = 1'b0;

        // Reset state
        #12;
        exp_q.push_back(0); check("rst_pwm",   int'(bus.PWM_sig));
        exp_q.push_back(0); check("rst_blank", int'(bus.OVR_I_blank_n));
        exp_q.push_back(0); check("rst_upd",   int'(bus.upd_pend));
        exp_q.push_back(0); check("rst_synch", int'(bus.PWM_synch));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // While disabled, the shadow loads and immediately transfers, and upd_pend clears the next cycle.
        @(negedge clk);
        bus.duty = {8'd0, 8'd0, 8'd64}; bus.duty_vld = 1'b1;
        @(negedge clk);
        bus.duty_vld = 1'b0;
        exp_q.push_back(1); check("en0_upd_set", int'(bus.upd_pend));
        @(negedge clk);
        exp_q.push_back(0); check("en0_upd_clr", int'(bus.upd_pend));
        exp_q.push_back(0); check("en0_pwm_low", int'(bus.PWM_sig));
        bus.en = 1'b1;
        wait_synch("first_synch", 300);

        // Step 1: edge mode, ch0 = 64
        exp_q.push_back(256); exp_q.push_back(64); exp_q.push_back(0); exp_q.push_back(0);
        exp_q.push_back(0);   exp_q.push_back(1);  exp_q.push_back(16); exp_q.push_back(0);
        measure(-1, '0, 1'b0);
        check("p1_len", m_len);     check("p1_hi0", m_hi[0]);   check("p1_hi1", m_hi[1]);
        check("p1_hi2", m_hi[2]);   check("p1_first0", m_first0); check("p1_rise0", m_rise0);
        check("p1_blank16", m_maxlow); check("p1_upd", m_upd);

        // Step 2: ch2 = 255 written at cnt 10, so upd_pend is high for cnt 11..255.
        exp_q.push_back(0); exp_q.push_back(245); exp_q.push_back(1);
        measure(10, {8'd255, 8'd0, 8'd64}, 1'b0);
        check("p2_hi2_old", m_hi[2]); check("p2_upd", m_upd); check("p2_end_upd", m_end_upd);
        exp_q.push_back(64); exp_q.push_back(0); exp_q.push_back(255); exp_q.push_back(0);
        measure(-1, '0, 1'b0);
        check("p3_hi0", m_hi[0]); check("p3_hi1_zero", m_hi[1]);
        check("p3_hi2_max", m_hi[2]); check("p3_upd", m_upd);

        // Step 3: ch0 = 100 written at cnt 50. Then ch0 = 30 written coincident with the boundary.
        exp_q.push_back(64); exp_q.push_back(205); exp_q.push_back(1);
        measure(50, {8'd255, 8'd0, 8'd100}, 1'b0);
        check("p4_hi0_old", m_hi[0]); check("p4_upd", m_upd); check("p4_end_upd", m_end_upd);
        bus.duty = {8'd255, 8'd0, 8'd30}; bus.duty_vld = 1'b1;
        exp_q.push_back(100); exp_q.push_back(256);
        measure(-1, '0, 1'b0);
        check("p5_hi0_new", m_hi[0]); check("p5_upd_coinc", m_upd);
        exp_q.push_back(30); exp_q.push_back(0);
        measure(-1, '0, 1'b0);
        check("p6_hi0_late", m_hi[0]); check("p6_upd", m_upd);

        // Step 4: center mode and ch0 = 10 requested at cnt 128
        exp_q.push_back(256); exp_q.push_back(30); exp_q.push_back(255);
        measure(128, {8'd0, 8'd0, 8'd10}, 1'b1);
        check("p7_len_edge", m_len); check("p7_hi0", m_hi[0]); check("p7_hi2", m_hi[2]);
        exp_q.push_back(510); exp_q.push_back(18);
        measure(-1, '0, 1'b0);
        check("p8_len_ctr", m_len); check("p8_hi0", m_hi[0]);
        exp_q.push_back(510); exp_q.push_back(19); exp_q.push_back(1); exp_q.push_back(1);
        exp_q.push_back(0);
        measure(-1, '0, 1'b0);
        check("p9_len_ctr", m_len); check("p9_hi0", m_hi[0]); check("p9_rise0", m_rise0);
        check("p9_first0", m_first0); check("p9_hi2", m_hi[2]);

        // Step 5: back to edge mode with ch0 = 90 and ch1 = 95, so the falling edges are 5 cycles apart.
        exp_q.push_back(510);
        measure(100, {8'd0, 8'd95, 8'd90}, 1'b0);
        check("p10_len_ctr", m_len);
        exp_q.push_back(256);
        measure(-1, '0, 1'b0);
        check("p11_len_edge", m_len);
        exp_q.push_back(256); exp_q.push_back(90); exp_q.push_back(95); exp_q.push_back(21);
        measure(-1, '0, 1'b0);
        check("p12_len", m_len); check("p12_hi0", m_hi[0]); check("p12_hi1", m_hi[1]);
        check("p12_blank21", m_maxlow);

        // Step 6: asynchronous reset mid-pulse with an update pending
        repeat (78) @(negedge clk);
        exp_q.push_back(3); check("pre_rst_pwm", int'(bus.PWM_sig));
        bus.duty = {8'd0, 8'd0, 8'd200}; bus.duty_vld = 1'b1;
        @(negedge clk);
        bus.duty_vld = 1'b0;
        exp_q.push_back(1); check("pre_rst_upd", int'(bus.upd_pend));
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(0); check("mid_rst_pwm",   int'(bus.PWM_sig));
        exp_q.push_back(0); check("mid_rst_blank", int'(bus.OVR_I_blank_n));
        exp_q.push_back(0); check("mid_rst_upd",   int'(bus.upd_pend));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_synch("post_rst_synch", 300);
        exp_q.push_back(256); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        exp_q.push_back(0);
        measure(-1, '0, 1'b0);
        check("p13_len", m_len); check("p13_hi0", m_hi[0]); check("p13_hi1", m_hi[1]);
        check("p13_hi2", m_hi[2]); check("p13_upd", m_upd);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
